coh_snoop_agent: RTL and testbench
==================================

Name: coh_snoop_agent

Overview:
- Per-CPU coherence agent: the cache-side counterpart of the two-CPU snooping bus arbiter.
- Requester half: turns cache read misses, write misses and shared-write upgrades into bus requests, holds the CPU stalled until the fill/invalidate completes, and reports the fill data source.
- Responder half: answers bus search and invalidate commands by looking up the local D-cache tag/state port, and commands downgrade or invalidate of the local line.
- Two instances sit in the design, one between each CPU D-cache and the bus.

Parameters:
- ADDR_W, 11, full block address width (BICO/BOCI).
- XFER_CYCLES, 4, fill cycles held after grant before completion (2..15).
- SRCH_HOLD, 2, cycles search_found is held once asserted (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cache_rd_miss  in  1  level; D-cache read miss pending
- cache_wr_miss  in  1  level; D-cache write miss pending
- cache_upgrade  in  1  level; write hit to SHARED block
- cache_addr  in  ADDR_W  address of pending miss/upgrade
- cache_blk_state  in  2  MSI state of addressed block (00 M, 01 S, 10 I)
- cpu_stall  out  1  stall CPU pipeline
- fill_done  out  1  one-cycle pulse; request complete
- fill_src  out  1  0 dmem, 1 other processor
- read_miss  out  1  to bus
- write_miss  out  1  to bus
- invalidate  out  1  to bus
- BICO  out  ADDR_W  request address to bus
- block_state  out  2  registered cache_blk_state of request
- grant  in  1  bus grant to this CPU
- datasel  in  1  bus data source select
- search  in  1  bus asks this cache to search BOCI
- inv_from_other  in  1  bus orders invalidate of BOCI
- BOCI  in  ADDR_W  bus snoop address
- search_found  out  1  valid block for BOCI held here
- snp_addr  out  ADDR_W  tag lookup address to D-cache (= BOCI, combinational)
- snp_hit  in  1  tag lookup hit (combinational from cache)
- snp_state  in  2  MSI state of hit line
- snp_downgrade  out  1  pulse; set local line M->S
- snp_inv  out  1  pulse; set local line ->I

Behaviour:
- Reset (rst at posedge): requester state IDLE, responder counter 0. All outputs 0, except BICO = 0 and block_state = 2'b10.
- Reset mid-operation aborts the request; the cache re-raises it.
- Requester FSM, states IDLE, REQ, XFER, DONE:
  - IDLE: samples requests with priority rd_miss > wr_miss > upgrade. Latches cache_addr into BICO, cache_blk_state into block_state, and the request type. -> REQ. cpu_stall rises the same cycle, combinational from any request input.
  - REQ: drives exactly one of read_miss/write_miss/invalidate until grant=1 is sampled. At that edge: fill_src <= datasel, counter <= 0, -> XFER. For an upgrade, go directly to DONE. Request lines drop on the cycle after grant is seen.
  - XFER: counter increments each cycle. fill_src is re-sampled from datasel on the first XFER cycle, because the bus resolves the source one cycle after grant. At counter == XFER_CYCLES-1, -> DONE.
  - DONE: fill_done=1 and cpu_stall=0 for one cycle. -> IDLE.
  - Requests that change while not in IDLE are ignored.
- Responder (independent of the requester, serviced in any requester state):
  - search=1: search_found is registered next cycle as snp_hit && snp_state != 2'b10. It is held SRCH_HOLD cycles, then cleared.
  - If found and snp_state == M: snp_downgrade pulses on that same cycle.
  - A new search during hold restarts the hold.
  - inv_from_other=1: snp_inv pulses next cycle if snp_hit && snp_state != I; otherwise nothing.
  - search and inv_from_other in the same cycle: invalidate wins, search_found = 0.
- Own-request collision: if inv_from_other hits BICO while in REQ with an upgrade pending, the upgrade is converted to a write miss. write_miss is asserted from the next cycle and block_state becomes I.
- Wrap: counter width is ceil(log2(XFER_CYCLES))+1 and never wraps within XFER.

Test Plan:
- Read miss, dmem: cache_rd_miss=1, addr=0x155, grant 2 cycles later, datasel=0 -> read_miss high 2 cycles, BICO=0x155, fill_done pulses 4 cycles after grant, fill_src=0.
- Read miss, forwarded: as above with datasel=1 on the first XFER cycle -> fill_src=1, fill_done after 4 XFER cycles, cpu_stall low on the fill_done cycle.
- Snoop hit M: search=1, BOCI=0x2A0, snp_hit=1, snp_state=00 -> search_found=1 for cycles +1..+2, snp_downgrade pulse at +1; with snp_state=10 -> search_found stays 0.
- Upgrade race: cache_upgrade=1 in REQ, then inv_from_other with BOCI=BICO before grant -> invalidate drops, write_miss asserted next cycle, block_state=10.
- Simultaneous search + inv_from_other on a hit S line -> snp_inv=1, search_found=0.
- rst asserted during XFER -> next cycle all outputs 0, state IDLE, no fill_done.

Source files
------------

// File: rtl/coh_snoop_agent.sv
// coh_snoop_agent: per-CPU coherence agent between a D-cache and the snooping bus.
// Ports: cache miss/upgrade in, stall/fill out; bus req/grant; snoop search/inv.
module coh_snoop_agent #(
  parameter int ADDR_W      = 11,
  parameter int XFER_CYCLES = 4,
  parameter int SRCH_HOLD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_rd_miss,
  input  logic              cache_wr_miss,
  input  logic              cache_upgrade,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [1:0]        cache_blk_state,
  output logic              cpu_stall,
  output logic              fill_done,
  output logic              fill_src,
  output logic              read_miss,
  output logic              write_miss,
  output logic              invalidate,
  output logic [ADDR_W-1:0] BICO,
  output logic [1:0]        block_state,
  input  logic              grant,
  input  logic              datasel,
  input  logic              search,
  input  logic              inv_from_other,
  input  logic [ADDR_W-1:0] BOCI,
  output logic              search_found,
  output logic [ADDR_W-1:0] snp_addr,
  input  logic              snp_hit,
  input  logic [1:0]        snp_state,
  output logic              snp_downgrade,
  output logic              snp_inv
);

  localparam int CW = $clog2(XFER_CYCLES) + 1;
  localparam int HW = $clog2(SRCH_HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(XFER_CYCLES - 1);
  localparam logic [HW-1:0] HOLD = HW'(SRCH_HOLD);
  localparam logic [1:0] ST_M = 2'b00;
  localparam logic [1:0] ST_I = 2'b10;

  typedef enum logic [1:0] {
    IDLE, REQ, XFER, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic          req_any;
  logic          collide;
  logic          snp_valid;

  assign req_any = cache_rd_miss | cache_wr_miss | cache_upgrade;

  // A snooped invalidate of our own upgrade target means our
  // shared copy is gone: the upgrade must become a full write miss.
  assign collide = invalidate & inv_from_other & (BOCI == BICO);

  assign cpu_stall = (state == REQ) | (state == XFER) |
                     ((state == IDLE) & req_any);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      BICO        <= '0;
      block_state <= ST_I;
      read_miss   <= 1'b0;
      write_miss  <= 1'b0;
      invalidate  <= 1'b0;
      fill_src    <= 1'b0;
      fill_done   <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_any) begin
            BICO        <= cache_addr;
            block_state <= cache_blk_state;
            read_miss   <= cache_rd_miss;
            write_miss  <= ~cache_rd_miss & cache_wr_miss;
            invalidate  <= ~cache_rd_miss & ~cache_wr_miss;
            state       <= REQ;
          end
        end
        REQ: begin
          if (collide) begin
            invalidate  <= 1'b0;
            write_miss  <= 1'b1;
            block_state <= ST_I;
          end else if (grant) begin
            read_miss  <= 1'b0;
            write_miss <= 1'b0;
            invalidate <= 1'b0;
            fill_src   <= datasel;
            cnt        <= '0;
            if (invalidate) begin
              state     <= DONE;
              fill_done <= 1'b1;
            end else begin
              state <= XFER;
            end
          end
        end
        XFER: begin
          cnt <= cnt + 1'b1;
          // Source is only resolved by the bus one cycle after grant.
          if (cnt == '0) fill_src <= datasel;
          if (cnt == LAST) begin
            state     <= DONE;
            fill_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign snp_addr     = BOCI;
  assign snp_valid    = snp_hit & (snp_state != ST_I);
  assign search_found = (hold != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold          <= '0;
      snp_downgrade <= 1'b0;
      snp_inv       <= 1'b0;
    end else begin
      snp_downgrade <= 1'b0;
      snp_inv       <= 1'b0;
      if (inv_from_other) begin
        snp_inv <= snp_valid;
        if (search) hold <= '0;
        else if (hold != '0) hold <= hold - 1'b1;
      end else if (search) begin
        hold          <= snp_valid ? HOLD : '0;
        snp_downgrade <= snp_valid & (snp_state == ST_M);
      end else if (hold != '0) begin
        hold <= hold - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coh_snoop_agent.sv
// tb_coh_snoop_agent: directed + random bench for coh_snoop_agent.
// Transaction-level model checked every cycle plus literal spot checks.
module tb_coh_snoop_agent;

  localparam int AW = 11;
  localparam int XC = 4;
  localparam int SH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cache_rd_miss, cache_wr_miss, cache_upgrade;
  logic [AW-1:0] cache_addr;
  logic [1:0]    cache_blk_state;
  logic          cpu_stall, fill_done, fill_src;
  logic          read_miss, write_miss, invalidate;
  logic [AW-1:0] BICO;
  logic [1:0]    block_state;
  logic          grant, datasel, search, inv_from_other;
  logic [AW-1:0] BOCI;
  logic          search_found;
  logic [AW-1:0] snp_addr;
  logic          snp_hit;
  logic [1:0]    snp_state;
  logic          snp_downgrade, snp_inv;

  always #5 clk = ~clk;

  coh_snoop_agent #(
    .ADDR_W(AW), .XFER_CYCLES(XC), .SRCH_HOLD(SH)
  ) dut (
    .clk(clk), .rst(rst),
    .cache_rd_miss(cache_rd_miss), .cache_wr_miss(cache_wr_miss),
    .cache_upgrade(cache_upgrade), .cache_addr(cache_addr),
    .cache_blk_state(cache_blk_state),
    .cpu_stall(cpu_stall), .fill_done(fill_done), .fill_src(fill_src),
    .read_miss(read_miss), .write_miss(write_miss),
    .invalidate(invalidate), .BICO(BICO), .block_state(block_state),
    .grant(grant), .datasel(datasel), .search(search),
    .inv_from_other(inv_from_other), .BOCI(BOCI),
    .search_found(search_found), .snp_addr(snp_addr),
    .snp_hit(snp_hit), .snp_state(snp_state),
    .snp_downgrade(snp_downgrade), .snp_inv(snp_inv)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(string nm, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding request, described by its kind
  // (0 read, 1 write, 2 upgrade), whether it still waits for grant,
  // and how many transfer cycles have elapsed.
  bit     m_active = 0;
  bit     m_wait = 0;
  bit     m_done = 0;
  int     m_kind = 0;
  int     m_addr = 0;
  int     m_bst = 2;
  int     m_src = 0;
  int     m_xn = 0;
  longint cyc = 0;
  longint sf_exp = -1;
  bit     m_dg = 0;
  bit     m_inv = 0;

  always @(negedge clk) begin
    bit any;
    bit vld;
    any = cache_rd_miss | cache_wr_miss | cache_upgrade;
    vld = snp_hit && (snp_state != 2'b10);
    chk("cpu_stall", int'(cpu_stall), int'(m_active || (!m_done && any)));
    chk("fill_done", int'(fill_done), int'(m_done));
    chk("fill_src", int'(fill_src), m_src);
    chk("read_miss", int'(read_miss), int'(m_wait && m_kind == 0));
    chk("write_miss", int'(write_miss), int'(m_wait && m_kind == 1));
    chk("invalidate", int'(invalidate), int'(m_wait && m_kind == 2));
    chk("BICO", int'(BICO), m_addr);
    chk("block_state", int'(block_state), m_bst);
    chk("search_found", int'(search_found), int'(cyc <= sf_exp));
    chk("snp_downgrade", int'(snp_downgrade), int'(m_dg));
    chk("snp_inv", int'(snp_inv), int'(m_inv));
    chk("snp_addr", int'(snp_addr), int'(BOCI));
    if (rst) begin
      m_active = 0; m_wait = 0; m_done = 0;
      m_addr = 0; m_bst = 2; m_src = 0;
      sf_exp = cyc; m_dg = 0; m_inv = 0;
    end else begin
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (any) begin
          m_kind = cache_rd_miss ? 0 : (cache_wr_miss ? 1 : 2);
          m_addr = int'(cache_addr);
          m_bst = int'(cache_blk_state);
          m_active = 1;
          m_wait = 1;
        end
      end else if (m_wait) begin
        if (m_kind == 2 && inv_from_other && int'(BOCI) == m_addr) begin
          m_kind = 1;
          m_bst = 2;
        end else if (grant) begin
          m_src = int'(datasel);
          m_wait = 0;
          m_xn = 0;
          if (m_kind == 2) begin
            m_active = 0;
            m_done = 1;
          end
        end
      end else begin
        if (m_xn == 0) m_src = int'(datasel);
        m_xn++;
        if (m_xn == XC) begin
          m_active = 0;
          m_done = 1;
        end
      end
      m_dg = 0;
      m_inv = 0;
      if (inv_from_other) begin
        m_inv = vld;
        if (search) sf_exp = cyc;
      end else if (search) begin
        sf_exp = vld ? cyc + SH : cyc;
        m_dg = vld && (snp_state == 2'b00);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cache_rd_miss = 0; cache_wr_miss = 0; cache_upgrade = 0;
    cache_addr = '0; cache_blk_state = 2'b00;
    grant = 0; datasel = 0; search = 0; inv_from_other = 0;
    BOCI = '0; snp_hit = 0; snp_state = 2'b00;
  endtask

  int seen;

  initial begin
    idle_in();
    rst = 1;
    tick(); tick();
    chk("rst_BICO", int'(BICO), 0);
    chk("rst_blk", int'(block_state), 2);
    chk("rst_stall", int'(cpu_stall), 0);
    chk("rst_found", int'(search_found), 0);
    rst = 0;

    // Read miss served from memory
    cache_rd_miss = 1; cache_addr = 11'h155; cache_blk_state = 2'b10;
    #1 chk("rd_stall_comb", int'(cpu_stall), 1);
    tick(); cache_rd_miss = 0;
    #1 chk("rd_req1", int'(read_miss), 1);
    chk("rd_bico", int'(BICO), 'h155);
    tick(); grant = 1; datasel = 0;
    #1 chk("rd_req2", int'(read_miss), 1);
    tick(); grant = 0;
    #1 chk("rd_drop", int'(read_miss), 0);
    chk("rd_xfer_stall", int'(cpu_stall), 1);
    repeat (3) begin
      tick();
      chk("rd_early_done", int'(fill_done), 0);
    end
    tick();
    chk("rd_done", int'(fill_done), 1);
    chk("rd_done_stall", int'(cpu_stall), 0);
    chk("rd_src", int'(fill_src), 0);
    tick();

    // Read miss forwarded by the other CPU
    cache_rd_miss = 1; cache_addr = 11'h0AA;
    tick(); cache_rd_miss = 0; grant = 1; datasel = 0;
    tick(); grant = 0; datasel = 1;
    tick(); datasel = 0;
    #1 chk("fw_src_early", int'(fill_src), 1);
    tick(); tick();
    chk("fw_no_done", int'(fill_done), 0);
    tick();
    chk("fw_done", int'(fill_done), 1);
    chk("fw_src", int'(fill_src), 1);
    chk("fw_stall", int'(cpu_stall), 0);
    tick();

    // Snoop hit on a modified line
    search = 1; BOCI = 11'h2A0; snp_hit = 1; snp_state = 2'b00;
    #1 chk("snp_addr_lit", int'(snp_addr), 'h2A0);
    tick(); search = 0; snp_hit = 0;
    #1 chk("srch_found1", int'(search_found), 1);
    chk("srch_dg1", int'(snp_downgrade), 1);
    tick();
    chk("srch_found2", int'(search_found), 1);
    chk("srch_dg2", int'(snp_downgrade), 0);
    tick();
    chk("srch_found3", int'(search_found), 0);
    search = 1; snp_hit = 1; snp_state = 2'b10;
    tick(); search = 0; snp_hit = 0;
    #1 chk("srch_inv_line", int'(search_found), 0);
    tick();

    // Upgrade overtaken by a remote invalidate of the same block
    cache_upgrade = 1; cache_addr = 11'h3C3; cache_blk_state = 2'b01;
    tick(); cache_upgrade = 0;
    #1 chk("upg_inv", int'(invalidate), 1);
    chk("upg_blk", int'(block_state), 1);
    inv_from_other = 1; BOCI = 11'h3C3; snp_hit = 0;
    tick(); inv_from_other = 0;
    #1 chk("upg_inv_drop", int'(invalidate), 0);
    chk("upg_wmiss", int'(write_miss), 1);
    chk("upg_blk_i", int'(block_state), 2);
    grant = 1;
    tick(); grant = 0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (fill_done) seen = 1;
    end
    chk("upg_done", seen, 1);
    tick();

    // Search and invalidate together on a shared line
    search = 1; inv_from_other = 1; BOCI = 11'h011;
    snp_hit = 1; snp_state = 2'b01;
    tick(); search = 0; inv_from_other = 0; snp_hit = 0;
    #1 chk("both_inv", int'(snp_inv), 1);
    chk("both_found", int'(search_found), 0);
    tick();

    // Reset during transfer
    cache_rd_miss = 1; cache_addr = 11'h7FF; cache_blk_state = 2'b01;
    tick(); cache_rd_miss = 0; grant = 1; datasel = 1;
    tick(); grant = 0;
    tick(); rst = 1;
    tick(); rst = 0; datasel = 0;
    #1 chk("xrst_stall", int'(cpu_stall), 0);
    chk("xrst_rm", int'(read_miss), 0);
    chk("xrst_src", int'(fill_src), 0);
    chk("xrst_bico", int'(BICO), 0);
    chk("xrst_blk", int'(block_state), 2);
    seen = 0;
    repeat (6) begin
      tick();
      if (fill_done) seen = 1;
    end
    chk("xrst_no_done", seen, 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      cache_rd_miss = ($urandom_range(0, 7) == 0);
      cache_wr_miss = ($urandom_range(0, 7) == 0);
      cache_upgrade = ($urandom_range(0, 5) == 0);
      cache_addr = AW'($urandom_range(0, 2047));
      cache_blk_state = 2'($urandom_range(0, 2));
      grant = ($urandom_range(0, 3) == 0);
      datasel = ($urandom_range(0, 1) == 1);
      search = ($urandom_range(0, 3) == 0);
      inv_from_other = ($urandom_range(0, 5) == 0);
      BOCI = ($urandom_range(0, 2) == 0) ? AW'(m_addr)
                                         : AW'($urandom_range(0, 2047));
      snp_hit = ($urandom_range(0, 1) == 1);
      snp_state = 2'($urandom_range(0, 3));
    end
    tick();
    idle_in();
    rst = 0;
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
